microroc_emulator: RTL and testbench

MICROROC_EMULATOR -- requirements
Module: microroc_emulator

---
 rtl/microroc_emulator.sv | 217 +++++++++++++++++++++
 tb/tb_microroc_emulator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/microroc_emulator.sv
// microroc_emulator: cycle-level stand-in for a MICROROC readout ASIC.
// Captures hit frames {CHIP_ID, BCID, HitPattern} during an acquisition window,
// signals saturation on CHIPSATB, and replays the frames as 16-bit words on request.
// Optional feature: define MICROROC_EMU_TRAILER_EN to append a trailer word
// {8'hEE, 4'h0, StoredFrames} after the last frame of every readout.
module microroc_emulator #(
  parameter int unsigned DEPTH        = 8,
  parameter logic [7:0]  CHIP_ID      = 8'h01,
  parameter int unsigned SAT_HOLD     = 4,
  parameter int unsigned READ_LATENCY = 16,
  parameter int unsigned END_PULSE    = 4
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        RESET_B,
  input  logic        PWR_ON_D,
  input  logic        START_ACQ,
  input  logic        StartReadout,
  input  logic        HitInject,
  input  logic [15:0] HitPattern,
  input  logic [3:0]  HitLimit,
  output logic        CHIPSATB,
  output logic        EndReadout,
  output logic [15:0] MicrorocData,
  output logic        MicrorocData_en,
  output logic [3:0]  StoredFrames,
  output logic [7:0]  OverflowCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACQ, S_SAT_HOLD, S_WAIT_SRO, S_SRO_LATENCY, S_READ_WORD, S_READ_GAP, S_END_READ
  } state_t;

  localparam logic [3:0]  DEPTH4 = 4'(DEPTH);
  localparam logic [15:0] SAT_M1 = 16'(SAT_HOLD - 1);
  localparam logic [15:0] LAT_M1 = 16'(READ_LATENCY - 1);
  localparam logic [15:0] END_M1 = 16'(END_PULSE - 1);

  state_t      r_state;
  logic [2:0]  r_acq_s, r_sro_s, r_hit_s;
  logic [23:0] r_bcid;
  logic [15:0] r_cnt;
  logic [3:0]  r_stored, r_rd_frame;
  logic [1:0]  r_word_sel;
  logic [7:0]  r_ovf;
  logic        r_chipsatb, r_end, r_en;
  logic [15:0] r_data;
  logic [39:0] r_mem [16];
`ifdef MICROROC_EMU_TRAILER_EN
  logic        r_trl_done;
`endif

  logic        w_acq_rise, w_acq_fall, w_sro_rise, w_hit_rise;
  logic [3:0]  w_limit;
  logic        w_store, w_more;
  logic [39:0] w_frame;
  logic [15:0] w_word;

  assign w_acq_rise = r_acq_s[1] & ~r_acq_s[2];
  assign w_acq_fall = ~r_acq_s[1] & r_acq_s[2];
  assign w_sro_rise = r_sro_s[1] & ~r_sro_s[2];
  assign w_hit_rise = r_hit_s[1] & ~r_hit_s[2];
  assign w_limit    = (HitLimit == 4'd0 || HitLimit > DEPTH4) ? DEPTH4 : HitLimit;
  // a hit coinciding with the end of the window is discarded, not counted as overflow
  assign w_store    = (r_state == S_ACQ) && !w_acq_fall && w_hit_rise && PWR_ON_D &&
                      (r_stored < w_limit);
  assign w_more     = (r_rd_frame < r_stored);
  assign w_frame    = r_mem[r_rd_frame];

  // select the readout word of the current frame
  always_comb begin
    w_word = '0;
    case (r_word_sel)
      2'd0:    w_word = {CHIP_ID, w_frame[39:32]};
      2'd1:    w_word = w_frame[31:16];
      default: w_word = w_frame[15:0];
    endcase
  end

  // frame store: {BCID, pattern}, chip id is constant and added on readout
  always_ff @(posedge Clk) begin
    if (w_store) r_mem[r_stored] <= {r_bcid, HitPattern};
  end

  // control FSM, synchronisers and registered outputs
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_acq_s    <= '0;
      r_sro_s    <= '0;
      r_hit_s    <= '0;
      r_bcid     <= '0;
      r_cnt      <= '0;
      r_stored   <= '0;
      r_rd_frame <= '0;
      r_word_sel <= '0;
      r_ovf      <= '0;
      r_chipsatb <= 1'b1;
      r_end      <= 1'b0;
      r_en       <= 1'b0;
      r_data     <= '0;
`ifdef MICROROC_EMU_TRAILER_EN
      r_trl_done <= 1'b0;
`endif
    end else if (!RESET_B) begin
      r_state    <= S_IDLE;
      r_acq_s    <= '0;
      r_sro_s    <= '0;
      r_hit_s    <= '0;
      r_bcid     <= '0;
      r_cnt      <= '0;
      r_stored   <= '0;
      r_rd_frame <= '0;
      r_word_sel <= '0;
      r_ovf      <= '0;
      r_chipsatb <= 1'b1;
      r_end      <= 1'b0;
      r_en       <= 1'b0;
      r_data     <= '0;
`ifdef MICROROC_EMU_TRAILER_EN
      r_trl_done <= 1'b0;
`endif
    end else begin
      r_acq_s <= {r_acq_s[1:0], START_ACQ};
      r_sro_s <= {r_sro_s[1:0], StartReadout};
      r_hit_s <= {r_hit_s[1:0], HitInject};
      r_en    <= 1'b0;
      r_data  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_acq_rise) begin
            r_bcid  <= '0;
            r_state <= S_ACQ;
          end
        end
        S_ACQ: begin
          r_bcid <= r_bcid + 24'd1;
          if (r_stored >= w_limit) r_chipsatb <= 1'b0;
          if (w_acq_fall) begin
            r_chipsatb <= 1'b0;
            r_cnt      <= SAT_M1;
            r_state    <= S_SAT_HOLD;
          end else if (w_store) begin
            r_stored <= r_stored + 4'd1;
          end else if (w_hit_rise && PWR_ON_D && r_ovf != 8'hFF) begin
            r_ovf <= r_ovf + 8'd1;
          end
        end
        S_SAT_HOLD: begin
          if (r_cnt == '0) begin
            r_chipsatb <= 1'b1;
            r_state    <= S_WAIT_SRO;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_WAIT_SRO: begin
          if (w_sro_rise) begin
            r_cnt      <= LAT_M1;
            r_rd_frame <= '0;
            r_word_sel <= '0;
`ifdef MICROROC_EMU_TRAILER_EN
            r_trl_done <= 1'b0;
`endif
            r_state    <= S_SRO_LATENCY;
          end
        end
        // latency expiry and the inter-word gap share the "emit next word" decision
        S_SRO_LATENCY, S_READ_GAP: begin
          if (r_state == S_SRO_LATENCY && r_cnt != '0) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (w_more) begin
            r_en    <= 1'b1;
            r_data  <= w_word;
            r_state <= S_READ_WORD;
            if (r_word_sel == 2'd2) begin
              r_word_sel <= '0;
              r_rd_frame <= r_rd_frame + 4'd1;
            end else begin
              r_word_sel <= r_word_sel + 2'd1;
            end
`ifdef MICROROC_EMU_TRAILER_EN
          end else if (!r_trl_done) begin
            r_en       <= 1'b1;
            r_data     <= {8'hEE, 4'h0, r_stored};
            r_trl_done <= 1'b1;
            r_state    <= S_READ_WORD;
`endif
          end else begin
            r_end   <= 1'b1;
            r_cnt   <= END_M1;
            r_state <= S_END_READ;
          end
        end
        S_READ_WORD: r_state <= S_READ_GAP;
        S_END_READ: begin
          if (r_cnt == '0) begin
            r_end    <= 1'b0;
            r_stored <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign CHIPSATB        = r_chipsatb;
  assign EndReadout      = r_end;
  assign MicrorocData    = r_data;
  assign MicrorocData_en = r_en;
  assign StoredFrames    = r_stored;
  assign OverflowCount   = r_ovf;

endmodule

// File: tb/tb_microroc_emulator.sv
// Directed/randomised bench for microroc_emulator with a frame-queue reference model.
module tb_microroc_emulator;

  localparam int END_W = 4;

  logic        Clk = 1'b0, reset_n = 1'b0, RESET_B = 1'b1, PWR_ON_D = 1'b1;
  logic        START_ACQ = 1'b0, StartReadout = 1'b0, HitInject = 1'b0;
  logic [15:0] HitPattern = '0;
  logic [3:0]  HitLimit = '0;
  logic        CHIPSATB, EndReadout, MicrorocData_en;
  logic [15:0] MicrorocData;
  logic [3:0]  StoredFrames;
  logic [7:0]  OverflowCount;

  microroc_emulator #(.DEPTH(8), .CHIP_ID(8'h01), .SAT_HOLD(4), .READ_LATENCY(16),
                      .END_PULSE(4)) dut (
    .Clk(Clk), .reset_n(reset_n), .RESET_B(RESET_B), .PWR_ON_D(PWR_ON_D),
    .START_ACQ(START_ACQ), .StartReadout(StartReadout), .HitInject(HitInject),
    .HitPattern(HitPattern), .HitLimit(HitLimit), .CHIPSATB(CHIPSATB),
    .EndReadout(EndReadout), .MicrorocData(MicrorocData), .MicrorocData_en(MicrorocData_en),
    .StoredFrames(StoredFrames), .OverflowCount(OverflowCount));

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc++;

  // output monitor, sampled on the falling edge
  logic [15:0] q[$];
  int end_cycles = 0, sat_low = 0, gap_err = 0, data_err = 0;
  logic prev_en = 1'b0;
  always @(negedge Clk) begin
    if (MicrorocData_en) begin
      q.push_back(MicrorocData);
      if (prev_en) gap_err++;
    end else if (MicrorocData !== 16'h0000) data_err++;
    if (EndReadout) end_cycles++;
    if (!CHIPSATB) sat_low++;
    prev_en = MicrorocData_en;
  end

  // reference model: stored frames in arrival order, overflow count, effective limit
  logic [23:0] m_bcid[$];
  logic [15:0] m_pat[$];
  int m_ovf = 0, m_limit = 8;
  int unsigned acq_cyc = 0;
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic set_limit(input logic [3:0] l);
    HitLimit = l;
    m_limit = (l == 0 || l > 8) ? 8 : int'(l);
  endtask

  task automatic start_acq();
    START_ACQ = 1'b1;
    acq_cyc = cyc;
    tick(6);
  endtask

  // every input passes through the same two-stage synchroniser, so the BCID
  // seen by a hit is its drive cycle minus the window-open drive cycle, less one
  task automatic hit(input logic [15:0] pat, input logic pwr, output int unsigned h);
    HitPattern = pat;
    PWR_ON_D = pwr;
    HitInject = 1'b1;
    h = cyc;
    tick(3);
    HitInject = 1'b0;
    tick(4);
    PWR_ON_D = 1'b1;
    if (pwr) begin
      if (m_pat.size() < m_limit) begin
        m_bcid.push_back(24'(h - acq_cyc - 1));
        m_pat.push_back(pat);
      end else if (m_ovf < 255) m_ovf++;
    end
  endtask

  // close the window; optionally with a hit on the very same cycle (must vanish)
  task automatic stop_acq(input logic with_hit);
    sat_low = 0;
    START_ACQ = 1'b0;
    if (with_hit) begin
      HitPattern = 16'hDEAD;
      HitInject = 1'b1;
    end
    tick(3);
    HitInject = 1'b0;
    tick(11);
  endtask

  task automatic readout(input string tag, input logic use_model);
    logic [15:0] exp[$];
    int n = 0;
    q.delete();
    end_cycles = 0;
    StartReadout = 1'b1;
    tick(3);
    StartReadout = 1'b0;
    while (!EndReadout && n < 400) begin tick(1); n++; end
    check({tag, "_eor_seen"}, 32'(n < 400), 32'd1);
    tick(8);
    check({tag, "_eor_width"}, 32'(end_cycles), 32'(END_W));
    check({tag, "_stored_clr"}, 32'(StoredFrames), 32'd0);
    if (use_model) begin
      foreach (m_pat[i]) begin
        exp.push_back({8'h01, m_bcid[i][23:16]});
        exp.push_back(m_bcid[i][15:0]);
        exp.push_back(m_pat[i]);
      end
`ifdef MICROROC_EMU_TRAILER_EN
      exp.push_back({8'hEE, 4'h0, 4'(m_pat.size())});
`endif
      check({tag, "_nwords"}, 32'(q.size()), 32'(exp.size()));
      foreach (exp[i])
        check($sformatf("%s_w%0d", tag, i), (i < q.size()) ? 32'(q[i]) : 32'hDEAD0000,
              32'(exp[i]));
    end
    m_bcid.delete();
    m_pat.delete();
  endtask

  initial begin
    int unsigned h1, h2, hx;
    logic [23:0] b1, b2;
    int n;

    // reset values
    tick(3);
    check("rst_chipsatb", 32'(CHIPSATB), 32'd1);
    check("rst_eor", 32'(EndReadout), 32'd0);
    check("rst_data", 32'(MicrorocData), 32'd0);
    check("rst_en", 32'(MicrorocData_en), 32'd0);
    check("rst_stored", 32'(StoredFrames), 32'd0);
    check("rst_ovf", 32'(OverflowCount), 32'd0);
    reset_n = 1'b1;
    tick(3);

    // two hits, readout request during acquisition ignored, hit at window close dropped
    set_limit(4'd0);
    start_acq();
    hit(16'hA5A5, 1'b1, h1);
    hit(16'h0F0F, 1'b1, h2);
    check("t1_stored", 32'(StoredFrames), 32'd2);
    StartReadout = 1'b1; tick(3); StartReadout = 1'b0; tick(3);
    stop_acq(1'b1);
    check("t1_sat_low", 32'(sat_low), 32'd4);
    check("t1_chipsatb_rel", 32'(CHIPSATB), 32'd1);
    check("t1_drop_at_stop", 32'(StoredFrames), 32'd2);
    tick(30);
    check("t1_sro_in_acq_ignored", 32'(q.size() + end_cycles), 32'd0);
    readout("t1", 1'b1);

    // limit 3, five random hits plus a powered-down hit
    set_limit(4'd3);
    start_acq();
    for (int i = 0; i < 5; i++) begin
      hit(16'($urandom), 1'b1, hx);
      if (i == 1) check("t2_csb_before_full", 32'(CHIPSATB), 32'd1);
      if (i == 2) check("t2_csb_full", 32'(CHIPSATB), 32'd0);
      tick(int'($urandom_range(0, 5)));
    end
    hit(16'h1234, 1'b0, hx);
    check("t2_ovf", 32'(OverflowCount), 32'(m_ovf));
    check("t2_ovf_const", 32'(OverflowCount), 32'd2);
    stop_acq(1'b0);
    readout("t2", 1'b1);

    // limit above DEPTH falls back to DEPTH; overflow persists across readouts
    set_limit(4'd12);
    start_acq();
    for (int i = 0; i < 10; i++) begin
      hit(16'($urandom), 1'b1, hx);
      tick(int'($urandom_range(0, 3)));
    end
    check("t3_stored", 32'(StoredFrames), 32'd8);
    stop_acq(1'b1);
    check("t3_ovf", 32'(OverflowCount), 32'(m_ovf));
    readout("t3", 1'b1);

    // no hits
    set_limit(4'd0);
    start_acq();
    stop_acq(1'b0);
    readout("t4", 1'b1);

    // BCID wrap: counter advanced near 2^24 instead of idling 16M cycles
    start_acq();
    force dut.r_bcid = 24'hFFFFF8;
    tick(1);
    release dut.r_bcid;
    hit(16'h5555, 1'b1, h1);
    hit(16'hAAAA, 1'b1, h2);
    stop_acq(1'b0);
    readout("t5", 1'b0);
    check("t5_nwords", 32'(q.size()), 32'd6);
    if (q.size() == 6) begin
      b1 = {q[0][7:0], q[1]};
      b2 = {q[3][7:0], q[4]};
      check("t5_delta", 32'(24'(b2 - b1)), 32'(24'(h2 - h1)));
      check("t5_b1_high", 32'(b1[23:4]), 32'hFFFFF);
      check("t5_b2_wrapped", 32'(b2 < 24'h20), 32'd1);
      check("t5_pat1", 32'(q[2]), 32'h5555);
      check("t5_pat2", 32'(q[5]), 32'hAAAA);
    end

    // RESET_B during a word strobe aborts the readout
    set_limit(4'd1);
    start_acq();
    for (int i = 0; i < 3; i++) hit(16'($urandom), 1'b1, hx);
    stop_acq(1'b0);
    check("t6_ovf_pre", 32'(OverflowCount), 32'(m_ovf));
    q.delete();
    end_cycles = 0;
    StartReadout = 1'b1; tick(3); StartReadout = 1'b0;
    n = 0;
    while (q.size() == 0 && n < 200) begin tick(1); n++; end
    check("t6_first_word", 32'(n < 200), 32'd1);
    tick(1);
    RESET_B = 1'b0;
    tick(1);
    RESET_B = 1'b1;
    check("t6_en", 32'(MicrorocData_en), 32'd0);
    check("t6_data", 32'(MicrorocData), 32'd0);
    check("t6_stored", 32'(StoredFrames), 32'd0);
    check("t6_ovf", 32'(OverflowCount), 32'd0);
    check("t6_csb", 32'(CHIPSATB), 32'd1);
    tick(40);
    check("t6_no_eor", 32'(end_cycles), 32'd0);
    check("t6_words", 32'(q.size()), 32'd2);
    m_ovf = 0;
    m_bcid.delete();
    m_pat.delete();

    // back in IDLE: a fresh acquisition works end to end
    set_limit(4'd0);
    start_acq();
    hit(16'hC3C3, 1'b1, hx);
    stop_acq(1'b0);
    readout("t7", 1'b1);

    check("gap_between_words", 32'(gap_err), 32'd0);
    check("data_zero_when_idle", 32'(data_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
